dmem_load_unit: RTL and testbench
=================================

// Module: dmem_load_unit
// PURPOSE
//  Read side of the RV32I data-memory path. Accepts one load request from the core.
//  Issues one word-aligned read to synchronous data memory and waits for its response.
//  Extracts the byte/halfword lane, zero- or sign-extends it, and returns a registered
//  result with a valid/error pulse. Complements the registered write-side strobes.
// PARAMETERS
//  TIMEOUT_CYC  16  WAIT-state cycles without mem_rvalid before the load is aborted with error (>=2)
//  CNT_W        5   width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  ld_req       in   1   load request; accepted when ld_req & ld_ready
//  ld_addr      in   32  byte address of load
//  ld_funct3    in   3   RV32I load funct3 (000 LB,001 LH,010 LW,100 LBU,101 LHU)
//  ld_ready     out  1   unit idle, can accept request (combinational from state)
//  ld_valid     out  1   one-cycle pulse: ld_data/ld_err valid
//  ld_data      out  32  extended load result (registered)
//  ld_err       out  1   qualifies ld_valid: illegal funct3, misaligned, or timeout
//  mem_re       out  1   memory read strobe, exactly one cycle per access (registered)
//  mem_addr     out  32  word address {addr[31:2],2'b00} (registered, held until next access)
//  mem_rdata    in   32  memory read data, sampled only with mem_rvalid
//  mem_rvalid   in   1   memory response strobe
// BEHAVIOUR
//  Reset: state IDLE; ld_valid=0, ld_err=0, ld_data=0, mem_re=0, mem_addr=0, counter=0.
//  FSM IDLE -> REQ -> WAIT -> IDLE. ld_ready=1 only in IDLE; ld_req outside IDLE ignored.
//  IDLE: on accept, latch ld_addr[1:0] and funct3; legal & aligned -> REQ; else set
//   ld_valid=1, ld_err=1, ld_data=0 next cycle, stay IDLE, no memory access.
//  REQ: mem_re=1, mem_addr driven; -> WAIT, counter cleared. mem_rvalid in REQ ignored.
//  WAIT: counter +1 per cycle. mem_rvalid -> register extracted data, ld_valid=1,
//   ld_err=0 next cycle, -> IDLE. counter==TIMEOUT_CYC-1 without rvalid -> ld_valid=1,
//   ld_err=1, ld_data=0, -> IDLE. rvalid on the timeout cycle: data wins, ld_err=0.
//  Latency (1-cycle memory): accept at T, mem_re at T+1, rvalid T+2, ld_valid T+3.
//  ld_valid cycle is IDLE: ld_ready=1, back-to-back requests accepted.
//  mem_rvalid in IDLE (stale/late response) ignored, no pulse generated.
//  Extraction: byte = mem_rdata[8*addr[1:0] +: 8]; half = addr[1] ? [31:16] : [15:0].
//   LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
//  Illegal funct3 (011,110,111) always -> error path, independent of macro.
//  Reset mid-transaction aborts immediately; no ld_valid for the abandoned load.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: LH with addr[0]=1 or LW with addr[1:0]!=0 takes the
//   error path (ld_err pulse, mem_re never asserted).
//  Undefined: misalignment ignored; LH uses addr[1] only, LW ignores addr[1:0]; normal read.
// TESTING
//  LW 0x0000_0010, mem_rdata=0xDEAD_BEEF, 1-cycle mem -> ld_data=0xDEAD_BEEF, ld_valid at T+3, ld_err=0.
//  LB/LBU 0x13, rdata=0x8012_3456 -> 0xFFFF_FF80 / 0x0000_0080; LH/LHU 0x12, rdata=0x8001_7FFF -> 0xFFFF_8001 / 0x0000_8001.
//  LW 0x11: with DMEM_MISALIGN_TRAP_EN -> ld_err=1, ld_data=0, no mem_re; without -> reads mem_addr=0x10.
//  funct3=011 -> ld_valid+ld_err next cycle, mem_re stays 0.
//  TIMEOUT_CYC=8, no rvalid -> ld_valid+ld_err after 8 WAIT cycles, ld_data=0, ld_ready returns.
//  reset asserted in WAIT, rvalid 2 cycles later -> no ld_valid; all outputs at reset values.

Source files
------------

// File: rtl/dmem_load_unit.sv
// RV32I data-memory load unit: one word-aligned synchronous read per load, lane extraction and sign/zero extension.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_load_unit #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [2:0]  ld_funct3_i,
  output logic        ld_ready_o,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic        ld_err_o,
  output logic        mem_re_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q;
  logic [1:0]       lane_q;
  logic [2:0]       funct3_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ld_valid_q;
  logic             ld_err_q;
  logic [31:0]      ld_data_q;
  logic             mem_re_q;
  logic [31:0]      mem_addr_q;

  logic             req_legal;
  logic             req_misaligned;
  logic             req_ok;

  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  lane,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    // NOTE: every local gets a value before any branch, so no path leaves it unassigned (no latch).
    res = '0;
    b   = rd[7:0];
    unique case (lane)
      2'd0: b = rd[7:0];
      2'd1: b = rd[15:8];
      2'd2: b = rd[23:16];
      2'd3: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (f3)
      F3_LB:   res = {{24{b[7]}}, b};
      F3_LH:   res = {{16{h[15]}}, h};
      F3_LW:   res = rd;
      F3_LBU:  res = {24'b0, b};
      F3_LHU:  res = {16'b0, h};
      default: res = '0;
    endcase
    return res;
  endfunction

  assign req_legal = (ld_funct3_i == F3_LB)  || (ld_funct3_i == F3_LH) ||
                     (ld_funct3_i == F3_LW)  || (ld_funct3_i == F3_LBU) ||
                     (ld_funct3_i == F3_LHU);

`ifdef DMEM_MISALIGN_TRAP_EN
  // Halfword loads (signed or unsigned) need an even address, words need a 4-byte boundary.
  assign req_misaligned = ((ld_funct3_i[1:0] == 2'b01) && ld_addr_i[0]) ||
                          ((ld_funct3_i == F3_LW) && (ld_addr_i[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_ok = req_legal && !req_misaligned;

  always_ff @(posedge clk) begin
    // NOTE: the whole unit resets synchronously so an in-flight load is dropped without a pulse.
    if (reset) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      funct3_q   <= '0;
      cnt_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_err_q   <= 1'b0;
      ld_data_q  <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values regardless of order.
      ld_valid_q <= 1'b0;
      ld_err_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ld_req_i) begin
            lane_q   <= ld_addr_i[1:0];
            funct3_q <= ld_funct3_i;
            if (req_ok) begin
              state_q    <= S_REQ;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {ld_addr_i[31:2], 2'b00};
            end else begin
              ld_valid_q <= 1'b1;
              ld_err_q   <= 1'b1;
              ld_data_q  <= '0;
            end
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          // A response arriving on the final allowed cycle still counts as data.
          if (mem_rvalid_i) begin
            ld_valid_q <= 1'b1;
            ld_data_q  <= extract(funct3_q, lane_q, mem_rdata_i);
            state_q    <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            ld_valid_q <= 1'b1;
            ld_err_q   <= 1'b1;
            ld_data_q  <= '0;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ld_ready_o = (state_q == S_IDLE);
  assign ld_valid_o = ld_valid_q;
  assign ld_err_o   = ld_err_q;
  assign ld_data_o  = ld_data_q;
  assign mem_re_o   = mem_re_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_dmem_load_unit.sv
// Self-checking bench for dmem_load_unit: directed vector table, hand-written corner sequences and
// randomized loads compared against an arithmetic reference model.
module tb_dmem_load_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic [2:0]  ld_funct3_i;
  logic        ld_ready_o;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic        ld_err_o;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_load_unit #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_req_i    (ld_req_i),
    .ld_addr_i   (ld_addr_i),
    .ld_funct3_i (ld_funct3_i),
    .ld_ready_o  (ld_ready_o),
    .ld_valid_o  (ld_valid_o),
    .ld_data_o   (ld_data_o),
    .ld_err_o    (ld_err_o),
    .mem_re_o    (mem_re_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] rd;
    int          lat;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outcome from the load rules: error or extended data, response cycle, number of reads.
  function automatic void ref_model(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                                    input int lat, output logic e, output logic [31:0] d,
                                    output int vc, output int nre);
    int unsigned off;
    logic [31:0] b;
    logic [31:0] hw;
    bit legal;
    bit mis;
    off   = a % 4;
    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    mis   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (((f3 == 1) || (f3 == 5)) && (off % 2 != 0)) mis = 1'b1;
    if ((f3 == 2) && (off != 0)) mis = 1'b1;
`endif
    e = 1'b1; d = 0; vc = 1; nre = 0;
    if (!legal || mis) return;
    nre = 1;
    if (lat >= 1 && lat <= TO) begin
      e  = 1'b0;
      vc = 2 + lat;
      b  = (rd >> (8 * off)) & 32'hFF;
      hw = (off >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
      case (f3)
        3'd0: d = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        3'd1: d = (hw >= 32768) ? (hw | 32'hFFFF_0000) : hw;
        3'd2: d = rd;
        3'd4: d = b;
        default: d = hw;
      endcase
    end else begin
      vc = 2 + TO;
    end
  endfunction

  // Issues one load in cycle 0 and plays a memory that answers lat cycles after mem_re (lat=0: never).
  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd, input int lat,
                          output bit got_valid, output logic err, output logic [31:0] data,
                          output int vcycle, output int re_count, output logic [31:0] maddr);
    int re_cycle;
    re_cycle  = -1;
    got_valid = 0;
    err = 1'b0; data = '0; vcycle = -1; re_count = 0; maddr = '0;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    ld_req_i = 1'b1; ld_addr_i = a; ld_funct3_i = f3;
    for (int n = 1; n <= 40 && !got_valid; n++) begin
      @(negedge clk);
      ld_req_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (mem_re_o) begin re_count++; re_cycle = n; maddr = mem_addr_o; end
      if (lat > 0 && re_cycle > 0 && n == re_cycle + lat) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = rd;
      end
      if (ld_valid_o) begin got_valid = 1; err = ld_err_o; data = ld_data_o; vcycle = n; end
    end
  endtask

  task automatic apply(input string tag, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                       input int lat, input logic exp_err, input logic [31:0] exp_data);
    bit got; logic err; logic [31:0] data; int vc; int nre; logic [31:0] maddr;
    logic m_e; logic [31:0] m_d; int m_vc; int m_nre;
    ref_model(a, f3, rd, lat, m_e, m_d, m_vc, m_nre);
    run_load(a, f3, rd, lat, got, err, data, vc, nre, maddr);
    check({tag, " valid_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " err"}, 32'(err), 32'(exp_err));
      check({tag, " data"}, data, exp_data);
      check({tag, " cycle"}, 32'(vc), 32'(m_vc));
    end
    check({tag, " re_count"}, 32'(nre), 32'(m_nre));
    if (m_nre > 0) check({tag, " mem_addr"}, maddr, a & 32'hFFFF_FFFC);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, 32'(ld_ready_o), 32'd1);
    check({tag, " valid"}, 32'(ld_valid_o), 32'd0);
    check({tag, " err"}, 32'(ld_err_o), 32'd0);
    check({tag, " data"}, ld_data_o, 32'd0);
    check({tag, " mem_re"}, 32'(mem_re_o), 32'd0);
    check({tag, " mem_addr"}, mem_addr_o, 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    logic m_e; logic [31:0] m_d; int m_vc; int m_nre;
    logic [31:0] a; logic [2:0] f3; logic [31:0] rd; int lat;

    vecs.push_back('{32'h10, 3'b010, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{32'h13, 3'b000, 32'h8012_3456, 1, 1'b0, 32'hFFFF_FF80});
    vecs.push_back('{32'h13, 3'b100, 32'h8012_3456, 1, 1'b0, 32'h0000_0080});
    vecs.push_back('{32'h12, 3'b001, 32'h8001_7FFF, 1, 1'b0, 32'hFFFF_8001});
    vecs.push_back('{32'h12, 3'b101, 32'h8001_7FFF, 1, 1'b0, 32'h0000_8001});
    vecs.push_back('{32'h10, 3'b001, 32'h8001_7FFF, 1, 1'b0, 32'h0000_7FFF});
    vecs.push_back('{32'h10, 3'b000, 32'h8012_3456, 1, 1'b0, 32'h0000_0056});
    vecs.push_back('{32'h12, 3'b000, 32'h8012_3456, 3, 1'b0, 32'h0000_0012});
    vecs.push_back('{32'h20, 3'b011, 32'h1111_1111, 1, 1'b1, 32'h0});
    vecs.push_back('{32'h20, 3'b110, 32'h1111_1111, 1, 1'b1, 32'h0});
    vecs.push_back('{32'h20, 3'b111, 32'h1111_1111, 1, 1'b1, 32'h0});
    vecs.push_back('{32'h40, 3'b010, 32'h5555_5555, 0, 1'b1, 32'h0});
    vecs.push_back('{32'h44, 3'b010, 32'h1234_5678, TO, 1'b0, 32'h1234_5678});
    vecs.push_back('{32'h48, 3'b010, 32'h1234_5678, TO + 1, 1'b1, 32'h0});
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back('{32'h11, 3'b010, 32'hDEAD_BEEF, 1, 1'b1, 32'h0});
    vecs.push_back('{32'h21, 3'b101, 32'hABCD_1234, 1, 1'b1, 32'h0});
`else
    vecs.push_back('{32'h11, 3'b010, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{32'h21, 3'b101, 32'hABCD_1234, 1, 1'b0, 32'h0000_1234});
`endif

    reset = 1'b1; ld_req_i = 1'b0; ld_addr_i = '0; ld_funct3_i = '0;
    mem_rdata_i = '0; mem_rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].addr, vecs[i].f3, vecs[i].rd, vecs[i].lat,
            vecs[i].exp_err, vecs[i].exp_data);

    // Back-to-back: error pulse cycle accepts the next request.
    @(negedge clk);
    ld_req_i = 1'b1; ld_addr_i = 32'h30; ld_funct3_i = 3'b011;
    @(negedge clk);
    check("b2b err_pulse", 32'({ld_valid_o, ld_err_o}), 32'b11);
    check("b2b ready", 32'(ld_ready_o), 32'd1);
    ld_addr_i = 32'h22; ld_funct3_i = 3'b001;
    @(negedge clk);
    ld_req_i = 1'b0;
    check("b2b mem_re", 32'(mem_re_o), 32'd1);
    check("b2b mem_addr", mem_addr_o, 32'h20);
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC3A5_0000;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("b2b data", ld_data_o, 32'hFFFF_C3A5);
    check("b2b valid", 32'({ld_valid_o, ld_err_o}), 32'b10);

    // Response during REQ is ignored (times out); late response in IDLE raises nothing.
    @(negedge clk);
    ld_req_i = 1'b1; ld_addr_i = 32'h50; ld_funct3_i = 3'b010;
    @(negedge clk);
    ld_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    for (int n = 2; n < 2 + TO; n++) begin
      check($sformatf("reqrv quiet%0d", n), 32'(ld_valid_o), 32'd0);
      @(negedge clk);
    end
    check("reqrv timeout", 32'({ld_valid_o, ld_err_o}), 32'b11);
    check("reqrv data", ld_data_o, 32'd0);
    mem_rvalid_i = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("stale ready", 32'(ld_ready_o), 32'd1);
    @(negedge clk);
    check("stale no_pulse", 32'(ld_valid_o), 32'd0);

    // Reset while waiting, response two cycles later.
    ld_req_i = 1'b1; ld_addr_i = 32'h60; ld_funct3_i = 3'b010;
    @(negedge clk);
    ld_req_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midrst");
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h9999_9999;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check($sformatf("midrst quiet%0d", n), 32'({ld_valid_o, ld_err_o}), 32'b00);
      @(negedge clk);
    end

    for (int i = 0; i < 150; i++) begin
      a   = $urandom;
      f3  = 3'($urandom_range(0, 7));
      rd  = $urandom;
      lat = $urandom_range(0, TO + 2);
      ref_model(a, f3, rd, lat, m_e, m_d, m_vc, m_nre);
      apply($sformatf("rnd%0d", i), a, f3, rd, lat, m_e, m_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
